// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and Data_Memory bus of the load/store unit.
// slave = load_store_unit, master = pipeline plus memory.
interface load_store_unit_if #(
  parameter int DW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [DW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_size,
    input  req_signed, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req_valid, req_write, req_size,
    output req_signed, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller: sub-word loads and RMW sub-word stores.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests return resp_err.
module load_store_unit #(
  parameter int              MEMORY_DEPTH = 64,
  parameter int              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h1001_0000
) (
  input logic           clk,
  input logic           reset,
  load_store_unit_if.slave bus
);

  localparam int AW = $clog2(MEMORY_DEPTH);
  localparam int DW = DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE, WR, LD_A, LD_D, RMW_A, RMW_W
  } state_t;

  state_t        state_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [1:0]    size_q;
  logic          sgn_q;
  logic          vld_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;

  logic [AW-1:0] widx;
  logic [DW-1:0] ld_val;
  logic [DW-1:0] mrg_val;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic          mis;
  logic          sub;

  // word index wraps modulo the memory depth
  assign widx = AW'((addr_q - BASE_ADDR) >> 2);

  assign bus.mem_addr   = DW'(widx);
  assign bus.mem_we     = (state_q == WR) ||
                          (state_q == RMW_W);
  assign bus.mem_wdata  = (state_q == RMW_W) ?
                          mrg_val : wdata_q;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = vld_q;
  assign bus.resp_rdata = rdata_q;

  assign sub = ~bus.req_size[1];

`ifdef MISALIGN_TRAP_EN
  assign mis = (bus.req_size == 2'b01 &&
                bus.req_addr[0]) ||
               (bus.req_size[1] &&
                bus.req_addr[1:0] != 2'b00);
  assign bus.resp_err = err_q;
`else
  assign mis = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  // lane extraction and sign/zero extension of load data
  always_comb begin
    ld_b = bus.mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_h = addr_q[1] ? bus.mem_rdata[31:16]
                     : bus.mem_rdata[15:0];
    ld_val = bus.mem_rdata;
    unique case (size_q)
      2'b00:   ld_val = {{24{sgn_q & ld_b[7]}}, ld_b};
      2'b01:   ld_val = {{16{sgn_q & ld_h[15]}}, ld_h};
      default: ld_val = bus.mem_rdata;
    endcase
  end

  // replace the target lane of the old word for RMW stores
  always_comb begin
    mrg_val = bus.mem_rdata;
    unique case (size_q)
      2'b00:
        mrg_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'b01:
        if (addr_q[1]) mrg_val[31:16] = wdata_q[15:0];
        else           mrg_val[15:0]  = wdata_q[15:0];
      default: mrg_val = wdata_q;
    endcase
  end

  // transaction FSM with registered response outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            if (mis) begin
              vld_q   <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= '0;
            end else if (bus.req_write) begin
              state_q <= sub ? RMW_A : WR;
            end else begin
              state_q <= LD_A;
            end
          end
        end
        WR, RMW_W: begin
          state_q <= IDLE;
          vld_q   <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        LD_A:  state_q <= LD_D;
        LD_D: begin
          state_q <= IDLE;
          vld_q   <= 1'b1;
          err_q   <= 1'b0;
          rdata_q <= ld_val;
        end
        RMW_A: state_q <= RMW_W;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
